ps2_key_rx: RTL

PS/2 keyboard receiver that turns the raw `ps2k_clk`/`ps2k_data` pins into decoded key events for the game logic. It samples device-clocked 11-bit frames and checks start, odd parity and stop bits. It strips the `E0` (extended) and `F0` (break) prefixes and publishes a one-cycle key event strobe. It also holds a held-key register (`ps2_byte`, `ps2_state`) that the VGA display/paddle logic reads directly. It sits between the board PS/2 pins and `VGA_display`, in the `clk_in` (50 MHz) domain.

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_filter.sv | 46 ++++
 rtl/ps2_key_rx.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, frame FSM states and timeout sizing for the PS/2 receiver
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

  // Counter must be able to hold TIMEOUT_CYC itself so it can saturate there.
  function automatic int tmo_width(input int cyc);
    return $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// rtl/ps2_filter.sv - pin synchronisers, PS/2 clock glitch filter and falling-edge pulse
module ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic ps2k_clk,
  input  logic ps2k_data,
  output logic fall,
  output logic data_sync
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_ff;
  logic [1:0]    dat_ff;
  logic          filt;
  logic [CW-1:0] cnt;

  // filt only follows the synchronised clock after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      clk_ff <= 2'b11;
      dat_ff <= 2'b11;
      filt   <= 1'b1;
      cnt    <= '0;
      fall   <= 1'b0;
    end else begin
      clk_ff <= {clk_ff[0], ps2k_clk};
      dat_ff <= {dat_ff[0], ps2k_data};
      fall   <= 1'b0;
      if (clk_ff[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        cnt  <= '0;
        filt <= clk_ff[1];
        fall <= ~clk_ff[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign data_sync = dat_ff[1];

endmodule

// File: rtl/ps2_key_rx.sv
// rtl/ps2_key_rx.sv - PS/2 frame receiver, E0/F0 prefix stripping and held-key register
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       ps2k_clk,
  input  logic       ps2k_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  output logic [7:0] ps2_byte,
  output logic       ps2_state,
  output logic       err
);

  localparam int            TW      = tmo_width(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);

  logic          fall;
  logic          data_sync;
  frame_state_t  state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_ok;
  logic [TW-1:0] tmo;
  logic [TW-1:0] tmo_inc;
  logic          timeout;
  logic          ext_f;
  logic          brk_f;

  ps2_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .ps2k_clk  (ps2k_clk),
    .ps2k_data (ps2k_data),
    .fall      (fall),
    .data_sync (data_sync)
  );

  assign tmo_inc = (tmo == TMO_MAX) ? tmo : tmo + 1'b1;
  assign timeout = (state != ST_IDLE) && !fall && (tmo_inc == TMO_MAX);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_ok    <= 1'b0;
      tmo       <= '0;
      ext_f     <= 1'b0;
      brk_f     <= 1'b0;
      key_code  <= '0;
      key_ext   <= 1'b0;
      key_break <= 1'b0;
      key_valid <= 1'b0;
      ps2_byte  <= '0;
      ps2_state <= 1'b0;
      err       <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      err       <= 1'b0;
      tmo       <= fall ? '0 : tmo_inc;
      if (timeout) begin
        state <= ST_IDLE;
        err   <= 1'b1;
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end else if (fall) begin
        case (state)
          ST_IDLE: begin
            if (!data_sync) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shreg   <= {data_sync, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_ok <= (^shreg) ^ data_sync;
            state  <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (!(data_sync && par_ok)) begin
              err   <= 1'b1;
              ext_f <= 1'b0;
              brk_f <= 1'b0;
            end else if (shreg == PS2_EXT) begin
              ext_f <= 1'b1;
            end else if (shreg == PS2_BRK) begin
              brk_f <= 1'b1;
            end else begin
              key_valid <= 1'b1;
              key_code  <= shreg;
              key_ext   <= ext_f;
              key_break <= brk_f;
              ext_f     <= 1'b0;
              brk_f     <= 1'b0;
              // Release only drops the held state when it names the held key
              if (!brk_f) begin
                ps2_byte  <= shreg;
                ps2_state <= 1'b1;
              end else if (shreg == ps2_byte) begin
                ps2_state <= 1'b0;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
